// File: rtl/mmac_tile_sequencer.sv
// Job sequencer for the MMAC datapath: command -> N operand pairs -> one lane-wise accumulated result.
// Optional build macro MMAC_SEQ_SAT_EN makes lane accumulation saturate instead of wrap.

package mmac_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int VAR_WIDTH  = 8;
endpackage

// One accumulator lane; lanes are independent so no carry ever crosses a lane boundary.
module mmac_seq_lane #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] acc,
  input  logic [VW-1:0] add,
  output logic [VW-1:0] sum
);
`ifdef MMAC_SEQ_SAT_EN
  logic [VW:0] raw;
  assign raw = {1'b0, acc} + {1'b0, add};
  assign sum = raw[VW] ? {VW{1'b1}} : raw[VW-1:0];
`else
  assign sum = acc + add;
`endif
endmodule

module mmac_tile_sequencer #(
  parameter int DATA_WIDTH = mmac_pkg::DATA_WIDTH,
  parameter int VAR_WIDTH  = mmac_pkg::VAR_WIDTH,
  parameter int MAX_TILES  = 16,
  localparam int TCW       = $clog2(MAX_TILES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  abort,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [TCW-1:0]        cmd_tiles,
  input  logic                  tile_valid,
  output logic                  tile_ready,
  input  logic [DATA_WIDTH-1:0] tile_a,
  input  logic [DATA_WIDTH-1:0] tile_b,
  output logic [DATA_WIDTH-1:0] mul_a,
  output logic [DATA_WIDTH-1:0] mul_b,
  input  logic [DATA_WIDTH-1:0] mul_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  busy,
  output logic [TCW-1:0]        tile_count
);
  localparam int LANES = DATA_WIDTH / VAR_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                          state, nstate;
  logic [TCW-1:0]                  n_q, cmd_n;
  logic                            mul_vld;
  logic                            cmd_hs, tile_hs, last_tile;
  logic [LANES-1:0][VAR_WIDTH-1:0] acc_q, acc_sum, prod;

  assign cmd_hs    = cmd_valid & cmd_ready;
  assign tile_hs   = tile_valid & tile_ready;
  assign cmd_n     = (cmd_tiles > TCW'(MAX_TILES)) ? TCW'(MAX_TILES) : cmd_tiles;
  assign last_tile = (tile_count == n_q - TCW'(1));
  assign prod      = mul_result;
  assign res_data  = acc_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mmac_seq_lane #(.VW(VAR_WIDTH)) u_lane (
      .acc (acc_q[l]),
      .add (prod[l]),
      .sum (acc_sum[l])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset)     state <= IDLE;
    else if (abort) state <= IDLE;
    else            state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (cmd_hs) nstate = (cmd_n == '0) ? DONE : RUN;
      RUN:     if (tile_hs && last_tile) nstate = DRAIN;
      DRAIN:   nstate = DONE;
      DONE:    if (res_valid && res_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Handshake outputs are masked during reset and in an abort cycle.
  always_comb begin
    cmd_ready  = 1'b0;
    tile_ready = 1'b0;
    res_valid  = 1'b0;
    busy       = reset && (state != IDLE);
    if (reset && !abort) begin
      case (state)
        IDLE:    cmd_ready  = 1'b1;
        RUN:     tile_ready = 1'b1;
        DONE:    res_valid  = 1'b1;
        default: ;
      endcase
    end
  end

  // mul_result reflects the operands registered on the previous handshake, hence mul_vld.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mul_a      <= '0;
      mul_b      <= '0;
      mul_vld    <= 1'b0;
      acc_q      <= '0;
      tile_count <= '0;
      n_q        <= '0;
    end else if (abort) begin
      mul_vld    <= 1'b0;
      acc_q      <= '0;
      tile_count <= '0;
    end else begin
      mul_vld <= tile_hs;
      if (tile_hs) begin
        mul_a      <= tile_a;
        mul_b      <= tile_b;
        tile_count <= tile_count + TCW'(1);
      end
      if (cmd_hs) begin
        n_q        <= cmd_n;
        acc_q      <= '0;
        tile_count <= '0;
      end else if (mul_vld) begin
        acc_q <= acc_sum;
      end
    end
  end
endmodule

// File: tb/tb_mmac_tile_sequencer.sv
// Bench for mmac_tile_sequencer: job table plus hand sequences for abort and reset, results scoreboarded.
module tb_mmac_tile_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        abort = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [4:0]  cmd_tiles = '0;
  logic        tile_valid = 1'b0, tile_ready;
  logic [31:0] tile_a = '0, tile_b = '0;
  logic [31:0] mul_a, mul_b, mul_result;
  logic        res_valid, res_ready = 1'b1;
  logic [31:0] res_data;
  logic        busy;
  logic [4:0]  tile_count;

  int vecs = 0, errs = 0, cyc = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int               cmdn;
    int               n;
    logic [15:0][31:0] tl;
    bit               gap;
    int               hold;
    logic [31:0]      exp;
  } vec_t;
  vec_t vt[6];

  assign mul_result = mul_a;

  mmac_tile_sequencer #(.DATA_WIDTH(32), .VAR_WIDTH(8), .MAX_TILES(16)) dut (
    .clock(clock), .reset(reset), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tiles(cmd_tiles),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_a(tile_a), .tile_b(tile_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .tile_count(tile_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Independent lane-wise reference sum.
  function automatic logic [31:0] model(int n, logic [15:0][31:0] tl);
    logic [3:0][7:0] a;
    logic [31:0]     w;
    logic [8:0]      s;
    a = '0;
    for (int i = 0; i < n; i++) begin
      w = tl[i];
      for (int l = 0; l < 4; l++) begin
        s = {1'b0, a[l]} + {1'b0, w[l*8 +: 8]};
`ifdef MMAC_SEQ_SAT_EN
        a[l] = s[8] ? 8'hFF : s[7:0];
`else
        a[l] = s[7:0];
`endif
      end
    end
    return a;
  endfunction

  always @(negedge clock) begin
    if (reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL unexpected_result: got %h with no result expected", res_data);
      end else begin
        chk("res_data", res_data, exp_q.pop_front());
      end
    end
  end

  task automatic send_cmd(input int cmdn, output bit ok);
    int t = 0;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_tiles = 5'(cmdn);
    @(negedge clock);
    while (!cmd_ready && t < 50) begin @(negedge clock); t++; end
    ok = cmd_ready;
    chk("cmd_accept", {31'b0, cmd_ready}, 32'd1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_job(input int cmdn, input int n, input logic [15:0][31:0] tl,
                         input bit gap, input int hold, input logic [31:0] exp);
    int t, k, first;
    bit ok;
    res_ready = (hold == 0);
    send_cmd(cmdn, ok);
    if (!ok) return;
    exp_q.push_back(exp);
    k = 0; first = -1; t = 0;
    if (n == 0) begin
      @(negedge clock);
      chk("empty_tile_ready", {31'b0, tile_ready}, 32'd0);
    end else begin
      while (k < n && t < 400) begin
        tile_valid = gap ? ~t[0] : 1'b1;
        tile_a = tl[k]; tile_b = ~tl[k];
        @(negedge clock);
        if (tile_valid && tile_ready) begin
          if (first < 0) first = cyc;
          k++;
        end
        @(posedge clock); #1;
        t++;
      end
      tile_valid = 1'b0;
      chk("tiles_accepted", k, n);
      @(negedge clock);
      chk("drain_tile_ready", {31'b0, tile_ready}, 32'd0);
      chk("mul_b_hold", mul_b, ~tl[n-1]);
    end
    t = 0;
    while (!res_valid && t < 50) begin @(negedge clock); t++; end
    chk("res_valid", {31'b0, res_valid}, 32'd1);
    if (!gap && n > 0) chk("latency", cyc - first, n + 1);
    chk("tile_count", tile_count, n);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        chk("hold_res_data", res_data, exp);
        chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge clock);
      end
      @(posedge clock); #1;
      res_ready = 1'b1;
      @(negedge clock);
    end
    @(posedge clock); #1;
    chk("busy_after_accept", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [15:0][31:0] tl;
    bit ok;
    int n;

    vt[0] = '{3, 3, '0, 1'b0, 0, 32'h0306090C};
    for (int i = 0; i < 3; i++) vt[0].tl[i] = 32'h01020304;
`ifdef MMAC_SEQ_SAT_EN
    vt[1] = '{2, 2, '0, 1'b0, 0, 32'hFF0000FF};
    vt[4] = '{4, 4, '0, 1'b0, 5, 32'hFF213142};
`else
    vt[1] = '{2, 2, '0, 1'b0, 0, 32'h01000000};
    vt[4] = '{4, 4, '0, 1'b0, 5, 32'h01213142};
`endif
    vt[1].tl[0] = 32'hFF000080; vt[1].tl[1] = 32'h02000080;
    vt[2] = '{0, 0, '0, 1'b0, 0, 32'h00000000};
    vt[3] = vt[0]; vt[3].gap = 1'b1;
    vt[4].tl[0] = 32'h10203040; vt[4].tl[1] = 32'h01010101;
    vt[4].tl[2] = 32'h00000001; vt[4].tl[3] = 32'hF0000000;
    vt[5] = '{31, 16, '0, 1'b0, 0, 32'h10101010};
    for (int i = 0; i < 16; i++) vt[5].tl[i] = 32'h01010101;

    // Reset state, during and after reset
    @(negedge clock);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_tile_ready", {31'b0, tile_ready}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_tile_count", tile_count, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    for (int v = 0; v < 6; v++)
      run_job(vt[v].cmdn, vt[v].n, vt[v].tl, vt[v].gap, vt[v].hold, vt[v].exp);

    // Abort mid-job after 2 of 4 tiles
    send_cmd(4, ok);
    tile_valid = 1'b1; tile_a = 32'h07070707;
    @(posedge clock); #1;
    @(posedge clock); #1;
    abort = 1'b1;
    @(negedge clock);
    chk("abort_tile_ready", {31'b0, tile_ready}, 32'd0);
    chk("abort_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    @(posedge clock); #1;
    abort = 1'b0; tile_valid = 1'b0;
    @(negedge clock);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_tile_count", tile_count, 32'd0);
    chk("abort_res_data", res_data, 32'd0);
    chk("abort_cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
    tl = '0; tl[0] = 32'h00000005;
    run_job(1, 1, tl, 1'b0, 0, 32'h00000005);

    // Abort while a result is pending in DONE
    res_ready = 1'b0;
    send_cmd(0, ok);
    @(negedge clock);
    chk("done_res_valid", {31'b0, res_valid}, 32'd1);
    @(posedge clock); #1;
    abort = 1'b1;
    @(negedge clock);
    chk("abort_done_res_valid", {31'b0, res_valid}, 32'd0);
    @(posedge clock); #1;
    abort = 1'b0; res_ready = 1'b1;
    @(negedge clock);
    chk("abort_done_idle", {31'b0, busy}, 32'd0);

    // Reset for one cycle after 1 of 3 tiles
    send_cmd(3, ok);
    tile_valid = 1'b1; tile_a = 32'h11223344; tile_b = 32'h55667788;
    @(posedge clock); #1;
    reset = 1'b0; tile_valid = 1'b0;
    @(negedge clock);
    chk("mrst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_tile_ready", {31'b0, tile_ready}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("mrst_mul_a", mul_a, 32'd0);
    chk("mrst_mul_b", mul_b, 32'd0);
    chk("mrst_res_data", res_data, 32'd0);
    chk("mrst_tile_count", tile_count, 32'd0);
    chk("mrst_cmd_ready_rel", {31'b0, cmd_ready}, 32'd1);
    chk("mrst_res_valid", {31'b0, res_valid}, 32'd0);
    tl = '0; tl[0] = 32'h01020304; tl[1] = 32'h10203040;
    run_job(2, 2, tl, 1'b0, 0, 32'h11223344);

    // A few random jobs against the lane model
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 6);
      tl = '0;
      for (int i = 0; i < n; i++) tl[i] = $urandom;
      run_job(n, n, tl, r[0], 0, model(n, tl));
    end

    repeat (3) @(posedge clock);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
